// File: rtl/acq_buf.sv
// acq_buf -- stream acquisition buffer.
//
// Captures an AXI4-stream sample flow into a circular on-chip buffer under an
// IDLE / ARM / POST state machine. It records the buffer index of the trigger
// sample and pulses irq when the post-trigger phase completes. Configuration,
// status and buffer contents are accessed through one system-bus slave port.
//
// Ports:
//   clk, rst          single clock, synchronous active-high reset
//   sti_tdata/tvalid  incoming samples; sti_tready is 1 except during rst
//   trg               external trigger pulses (masked by cfg_trg)
//   tro               one-cycle pulse when a trigger is accepted
//   irq               one-cycle pulse when a capture completes
//   bus_*             register / buffer access port; ack one cycle after strobe
module acq_buf #(
    parameter int DW = 16,
    parameter int AW = 14,
    parameter int TN = 1,
    parameter int CW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] sti_tdata,
    input  logic          sti_tvalid,
    output logic          sti_tready,
    input  logic [TN-1:0] trg,
    output logic          tro,
    output logic          irq,
    input  logic          bus_wen,
    input  logic          bus_ren,
    input  logic [31:0]   bus_addr,
    input  logic [31:0]   bus_wdata,
    output logic [31:0]   bus_rdata,
    output logic          bus_ack,
    output logic          bus_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        POST = 2'd2
    } state_t;

    state_t state, state_n;

    logic [CW-1:0] cfg_pre, cfg_pst, sts_pre, sts_pst, pst_inc;
    logic [TN-1:0] cfg_trg;
    logic [AW-1:0] sts_ptr, wpt;
    logic          done, trig_pend;
    logic          cmd_reset, cmd_start, cmd_stop, cmd_swtrg;

    logic [DW-1:0] mem [0:(1<<AW)-1];
    logic [DW-1:0] ram_q;
    logic [31:0]   reg_q, reg_rd;
    logic          rd_buf_q;

    logic          beat, trig_hit, accept, fire, finish, wr;
    logic          sel_buf, ctl_wr;
    logic [6:0]    reg_addr;
    logic [AW-1:0] buf_addr;
    logic          unused_bits;

    assign beat       = sti_tvalid;
    assign sel_buf    = bus_addr[AW+2];
    assign reg_addr   = bus_addr[6:0];
    assign buf_addr   = bus_addr[AW+1:2];
    assign ctl_wr     = bus_wen && !sel_buf && (reg_addr == 7'h00);
    assign pst_inc    = sts_pst + CW'(1);
    assign trig_hit   = (|(trg & cfg_trg)) || cmd_swtrg;
    assign sti_tready = ~rst;
    assign bus_err    = 1'b0;
    assign bus_rdata  = rd_buf_q ? 32'(ram_q) : reg_q;
    assign unused_bits = ^{bus_addr[31:AW+3], bus_addr[1:0], bus_wdata[31:4]};

    // Control bits are registered so they act one cycle after the bus write
    // and clear themselves; configuration registers load directly.
    always_ff @(posedge clk) begin
        if (rst) begin
            cmd_reset <= 1'b0;
            cmd_start <= 1'b0;
            cmd_stop  <= 1'b0;
            cmd_swtrg <= 1'b0;
            cfg_trg   <= '0;
            cfg_pre   <= '0;
            cfg_pst   <= '0;
        end else begin
            cmd_reset <= ctl_wr && bus_wdata[0];
            cmd_start <= ctl_wr && bus_wdata[1];
            cmd_stop  <= ctl_wr && bus_wdata[2];
            cmd_swtrg <= ctl_wr && bus_wdata[3];
            if (bus_wen && !sel_buf) begin
                case (reg_addr)
                    7'h08:   cfg_trg <= bus_wdata[TN-1:0];
                    7'h10:   cfg_pre <= bus_wdata[CW-1:0];
                    7'h14:   cfg_pst <= bus_wdata[CW-1:0];
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    // Next state and per-cycle strobes. reset/stop commands take priority
    // over everything else, so the beat of that cycle is dropped. A pending
    // trigger (or one accepted this cycle) is resolved by the next ARM beat.
    always_comb begin
        state_n = state;
        accept  = 1'b0;
        fire    = 1'b0;
        finish  = 1'b0;
        wr      = 1'b0;
        if (cmd_reset || cmd_stop) begin
            state_n = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_start) state_n = ARM;
                end
                ARM: begin
                    wr     = beat;
                    accept = trig_hit && !trig_pend && (sts_pre == cfg_pre);
                    if (beat && (trig_pend || accept)) begin
                        fire = 1'b1;
                        if (cfg_pst == '0) begin
                            finish  = 1'b1;
                            state_n = IDLE;
                        end else begin
                            state_n = POST;
                        end
                    end
                end
                POST: begin
                    wr = beat;
                    if (beat && (pst_inc == cfg_pst)) begin
                        finish  = 1'b1;
                        state_n = IDLE;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    // Counters, write pointer, trigger bookkeeping and the event pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            sts_pre   <= '0;
            sts_pst   <= '0;
            sts_ptr   <= '0;
            wpt       <= '0;
            done      <= 1'b0;
            trig_pend <= 1'b0;
            tro       <= 1'b0;
            irq       <= 1'b0;
        end else begin
            tro <= accept;
            irq <= finish;
            if (cmd_reset) begin
                sts_pre   <= '0;
                sts_pst   <= '0;
                sts_ptr   <= '0;
                wpt       <= '0;
                done      <= 1'b0;
                trig_pend <= 1'b0;
            end else if (cmd_stop) begin
                trig_pend <= 1'b0;
            end else begin
                if (state == IDLE && cmd_start) begin
                    sts_pre <= '0;
                    sts_pst <= '0;
                    done    <= 1'b0;
                end
                if (wr) wpt <= wpt + AW'(1);
                if (state == ARM && beat && !fire && (sts_pre < cfg_pre))
                    sts_pre <= sts_pre + CW'(1);
                if (fire) begin
                    trig_pend <= 1'b0;
                    sts_ptr   <= wpt;
                    sts_pst   <= '0;
                end else if (accept) begin
                    trig_pend <= 1'b1;
                end
                if (state == POST && beat) sts_pst <= pst_inc;
                if (finish) done <= 1'b1;
            end
        end
    end

    // Sample RAM: read-before-write, so a colliding read returns old data.
    always_ff @(posedge clk) begin
        if (wr && !rst) mem[wpt] <= sti_tdata;
        if (bus_ren && sel_buf) ram_q <= mem[buf_addr];
    end

    always_comb begin
        reg_rd = '0;
        case (reg_addr)
            7'h00:   reg_rd = {29'd0, done, (state == POST), (state == ARM)};
            7'h08:   reg_rd = 32'(cfg_trg);
            7'h10:   reg_rd = 32'(cfg_pre);
            7'h14:   reg_rd = 32'(cfg_pst);
            7'h18:   reg_rd = 32'(sts_pre);
            7'h1c:   reg_rd = 32'(sts_pst);
            7'h20:   reg_rd = 32'(sts_ptr);
            7'h24:   reg_rd = 32'(wpt);
            default: reg_rd = '0;
        endcase
    end

    // Bus response: rd_buf_q steers the output mux between register and RAM data.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus_ack  <= 1'b0;
            rd_buf_q <= 1'b0;
            reg_q    <= '0;
        end else begin
            bus_ack <= bus_wen || bus_ren;
            if (bus_ren) begin
                rd_buf_q <= sel_buf;
                if (!sel_buf) reg_q <= reg_rd;
            end
        end
    end

endmodule

// File: tb/tb_acq_buf.sv
// tb_acq_buf -- testbench for acq_buf (AW=4, TN=2).
//
// A behavioural model of the capture rules runs alongside the DUT and a
// compare process checks tro, irq, sti_tready, bus_ack and bus_rdata every
// cycle. Directed scenarios add literal expectations on top, followed by
// randomized stream, trigger, reset and bus traffic.
module tb_acq_buf;

    localparam int DEPTH = 16;
    localparam logic [31:0] BUFB = 32'h40;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] sti_tdata;
    logic        sti_tvalid;
    logic        sti_tready;
    logic [1:0]  trg;
    logic        tro, irq;
    logic        bus_wen, bus_ren;
    logic [31:0] bus_addr, bus_wdata, bus_rdata;
    logic        bus_ack, bus_err;

    acq_buf #(.DW(16), .AW(4), .TN(2), .CW(32)) dut (
        .clk(clk), .rst(rst),
        .sti_tdata(sti_tdata), .sti_tvalid(sti_tvalid), .sti_tready(sti_tready),
        .trg(trg), .tro(tro), .irq(irq),
        .bus_wen(bus_wen), .bus_ren(bus_ren), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_rdata(bus_rdata),
        .bus_ack(bus_ack), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int misses  = 0;
    bit checking = 0;

    // Model state: mode 0 idle, 1 armed, 2 post-trigger.
    int          mMode, mPtr, mWp;
    logic [31:0] mPre, mPst, mCfgPre, mCfgPst;
    logic [1:0]  mCfgTrg;
    bit          mDone, mPend;
    logic [3:0]  mCtl;
    logic [15:0] mMem [DEPTH];
    bit          mKnown [DEPTH];
    bit          expTro, expIrq, expAck, expRdValid;
    logic [31:0] expRdata;

    task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            misses++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance the model by one clock edge using the inputs present at that edge.
    task automatic modelStep();
        logic [3:0] ctl;
        int idx;
        if (rst) begin
            mMode = 0; mPre = 0; mPst = 0; mCfgPre = 0; mCfgPst = 0; mCfgTrg = 0;
            mPtr = 0; mWp = 0; mDone = 0; mPend = 0; mCtl = 0;
            expTro = 0; expIrq = 0; expAck = 0; expRdValid = 1; expRdata = 0;
            return;
        end
        expAck = bus_wen | bus_ren;
        if (bus_ren) begin
            if (bus_addr[6]) begin
                idx = int'(bus_addr[5:2]);
                expRdValid = mKnown[idx];
                expRdata = {16'd0, mMem[idx]};
            end else begin
                expRdValid = 1;
                case (bus_addr[6:0])
                    7'h00: expRdata = (mMode == 1 ? 32'd1 : 32'd0) | (mMode == 2 ? 32'd2 : 32'd0)
                                      | (mDone ? 32'd4 : 32'd0);
                    7'h08: expRdata = {30'd0, mCfgTrg};
                    7'h10: expRdata = mCfgPre;
                    7'h14: expRdata = mCfgPst;
                    7'h18: expRdata = mPre;
                    7'h1c: expRdata = mPst;
                    7'h20: expRdata = 32'(mPtr);
                    7'h24: expRdata = 32'(mWp);
                    default: expRdata = 0;
                endcase
            end
        end
        ctl = mCtl;
        mCtl = (bus_wen && bus_addr[6:0] == 7'h00) ? bus_wdata[3:0] : 4'd0;
        expTro = 0;
        expIrq = 0;
        if (ctl[0]) begin
            mMode = 0; mPre = 0; mPst = 0; mWp = 0; mDone = 0; mPend = 0; mPtr = 0;
        end else if (ctl[2]) begin
            mMode = 0; mPend = 0;
        end else if (mMode == 0) begin
            if (ctl[1]) begin mMode = 1; mPre = 0; mPst = 0; mDone = 0; end
        end else begin
            if (mMode == 1 && (((trg & mCfgTrg) != 0) || ctl[3]) && !mPend && mPre == mCfgPre) begin
                expTro = 1;
                mPend = 1;
            end
            if (sti_tvalid) begin
                mMem[mWp] = sti_tdata;
                mKnown[mWp] = 1;
                if (mMode == 1) begin
                    if (mPend) begin
                        mPend = 0; mPtr = mWp; mPst = 0;
                        if (mCfgPst == 0) begin mMode = 0; mDone = 1; expIrq = 1; end
                        else mMode = 2;
                    end else if (mPre < mCfgPre) begin
                        mPre++;
                    end
                end else begin
                    mPst++;
                    if (mPst == mCfgPst) begin mMode = 0; mDone = 1; expIrq = 1; end
                end
                mWp = (mWp + 1) % DEPTH;
            end
        end
        if (bus_wen) begin
            case (bus_addr[6:0])
                7'h08: mCfgTrg = bus_wdata[1:0];
                7'h10: mCfgPre = bus_wdata;
                7'h14: mCfgPst = bus_wdata;
                default: ;
            endcase
        end
    endtask

    // One clock: DUT and model both see the current inputs at the edge.
    task automatic applyStimulus();
        @(posedge clk);
        modelStep();
        #2;
    endtask

    task automatic checkOutput();
        checkVal("tro", {31'd0, tro}, {31'd0, expTro});
        checkVal("irq", {31'd0, irq}, {31'd0, expIrq});
        checkVal("ack", {31'd0, bus_ack}, {31'd0, expAck});
        checkVal("tready", {31'd0, sti_tready}, {31'd0, ~rst});
        if (expRdValid) checkVal("rdata", bus_rdata, expRdata);
    endtask

    initial forever begin
        @(negedge clk);
        if (checking) checkOutput();
    end

    task automatic idleInputs();
        sti_tvalid = 0; sti_tdata = 0; trg = 0;
        bus_wen = 0; bus_ren = 0; bus_addr = 0; bus_wdata = 0;
    endtask

    task automatic busWrite(input logic [31:0] a, input logic [31:0] d);
        bus_wen = 1; bus_addr = a; bus_wdata = d;
        applyStimulus();
        bus_wen = 0;
    endtask

    task automatic busRead(input logic [31:0] a, output logic [31:0] d);
        bus_ren = 1; bus_addr = a;
        applyStimulus();
        bus_ren = 0;
        d = bus_rdata;
    endtask

    task automatic expectReg(input string name, input logic [31:0] a, input logic [31:0] exp);
        logic [31:0] d;
        busRead(a, d);
        checkVal(name, d, exp);
    endtask

    // reset command then start; the extra cycle lets the start take effect.
    task automatic rearm();
        busWrite(0, 1);
        busWrite(0, 2);
        applyStimulus();
    endtask

    // Ramp stream; a beat happens every 'period' cycles carrying its beat index.
    task automatic runStream(input int n, input int period, input int t1, input int t2,
                             input int swBeat, input int stopBeat, input int rdBeat,
                             output int troCnt, output int troBeat,
                             output int irqCnt, output int irqBeat, output logic [31:0] rdVal);
        int b;
        bit v;
        b = 0; troCnt = 0; troBeat = -1; irqCnt = 0; irqBeat = -1; rdVal = 0;
        for (int c = 0; c < n; c++) begin
            v = (c % period) == 0;
            sti_tvalid = v;
            sti_tdata  = 16'(b);
            trg        = (v && (b == t1 || b == t2)) ? 2'b01 : 2'b00;
            bus_wen    = v && (b == swBeat || b == stopBeat);
            bus_addr   = 0;
            bus_wdata  = (b == stopBeat) ? 32'd4 : 32'd8;
            bus_ren    = v && (b == rdBeat);
            applyStimulus();
            if (tro) begin troCnt++; troBeat = b; end
            if (irq) begin irqCnt++; irqBeat = b; end
            if (bus_ren) rdVal = bus_rdata;
            if (v) b++;
        end
        idleInputs();
    endtask

    int troCnt, troBeat, irqCnt, irqBeat, r;
    logic [31:0] rdVal;

    initial begin
        rst = 1;
        idleInputs();
        applyStimulus();
        checking = 1;
        applyStimulus();
        checkVal("rst_rdata", bus_rdata, 0);
        checkVal("rst_tready", {31'd0, sti_tready}, 0);
        rst = 0;
        applyStimulus();
        expectReg("rst_status", 32'h00, 0);
        expectReg("rst_cfg_pre", 32'h10, 0);

        $display("[TB] pre=4 pst=3 trigger at beat 10");
        busWrite(32'h08, 1);
        busWrite(32'h10, 4);
        busWrite(32'h14, 3);
        busWrite(0, 2);
        applyStimulus();
        runStream(20, 1, 10, -1, -1, -1, -1, troCnt, troBeat, irqCnt, irqBeat, rdVal);
        checkVal("t1_tro_cnt", 32'(troCnt), 1);
        checkVal("t1_tro_beat", 32'(troBeat), 10);
        checkVal("t1_irq_beat", 32'(irqBeat), 13);
        expectReg("t1_ptr", 32'h20, 10);
        expectReg("t1_status", 32'h00, 4);
        for (int i = 10; i <= 13; i++) expectReg("t1_buf", BUFB + 32'(i * 4), 32'(i));

        $display("[TB] early trigger dropped, second accepted");
        rearm();
        runStream(14, 1, 2, 6, -1, -1, 4, troCnt, troBeat, irqCnt, irqBeat, rdVal);
        checkVal("t2_status_arm", rdVal, 1);
        checkVal("t2_tro_cnt", 32'(troCnt), 1);
        checkVal("t2_tro_beat", 32'(troBeat), 6);
        expectReg("t2_ptr", 32'h20, 6);

        $display("[TB] software trigger with pst=0");
        busWrite(32'h14, 0);
        rearm();
        runStream(12, 1, -1, -1, 6, -1, -1, troCnt, troBeat, irqCnt, irqBeat, rdVal);
        checkVal("t3_tro_beat", 32'(troBeat), 7);
        checkVal("t3_irq_beat", 32'(irqBeat), 7);
        expectReg("t3_ptr", 32'h20, 7);
        expectReg("t3_wpt", 32'h24, 8);
        expectReg("t3_status", 32'h00, 4);

        $display("[TB] pointer wrap");
        busWrite(32'h10, 20);
        busWrite(32'h14, 2);
        rearm();
        runStream(32, 1, 25, -1, -1, -1, -1, troCnt, troBeat, irqCnt, irqBeat, rdVal);
        checkVal("t4_irq_beat", 32'(irqBeat), 27);
        expectReg("t4_ptr", 32'h20, 9);
        expectReg("t4_wpt", 32'h24, 12);
        for (int i = 0; i < 3; i++) expectReg("t4_buf", BUFB + 32'((9 + i) * 4), 32'(25 + i));

        $display("[TB] gaps in tvalid during post");
        busWrite(32'h10, 2);
        busWrite(32'h14, 3);
        rearm();
        runStream(40, 3, 4, -1, -1, -1, -1, troCnt, troBeat, irqCnt, irqBeat, rdVal);
        checkVal("t5_irq_beat", 32'(irqBeat), 7);
        checkVal("t5_irq_cnt", 32'(irqCnt), 1);
        expectReg("t5_pst", 32'h1c, 3);
        expectReg("t5_ptr", 32'h20, 4);

        $display("[TB] stop during post");
        busWrite(32'h14, 10);
        rearm();
        runStream(12, 1, 3, -1, -1, 6, -1, troCnt, troBeat, irqCnt, irqBeat, rdVal);
        checkVal("t6_irq_cnt", 32'(irqCnt), 0);
        expectReg("t6_status", 32'h00, 0);
        busWrite(0, 2);
        applyStimulus();
        expectReg("t6_pre", 32'h18, 0);
        expectReg("t6_status_arm", 32'h00, 1);

        $display("[TB] random traffic");
        for (int c = 0; c < 3000; c++) begin
            idleInputs();
            rst = ($urandom_range(0, 599) == 0);
            sti_tvalid = ($urandom_range(0, 3) != 0);
            sti_tdata = 16'($urandom);
            if ($urandom_range(0, 11) == 0) trg = 2'($urandom);
            r = $urandom_range(0, 19);
            if (r == 0) begin
                bus_wen = 1;
                case ($urandom_range(0, 9))
                    0, 1, 2, 3, 4: bus_wdata = 2;
                    5: bus_wdata = 8;
                    6: bus_wdata = 4;
                    7: bus_wdata = 1;
                    8: bus_wdata = 6;
                    default: bus_wdata = 32'($urandom_range(0, 15));
                endcase
            end else if (r == 1) begin
                bus_wen = 1;
                case ($urandom_range(0, 3))
                    0: begin bus_addr = 32'h08; bus_wdata = 32'($urandom_range(0, 3)); end
                    1: begin bus_addr = 32'h10; bus_wdata = 32'($urandom_range(0, 12)); end
                    2: begin bus_addr = 32'h14; bus_wdata = 32'($urandom_range(0, 5)); end
                    default: begin bus_addr = BUFB + 32'($urandom_range(0, 15) * 4); bus_wdata = $urandom; end
                endcase
            end else if (r < 6) begin
                bus_ren = 1;
                if ($urandom_range(0, 1) == 0) bus_addr = BUFB + 32'($urandom_range(0, 15) * 4);
                else bus_addr = 32'($urandom_range(0, 10) * 4);
            end
            applyStimulus();
        end
        rst = 0;
        idleInputs();
        applyStimulus();
        applyStimulus();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, misses);
        $finish;
    end

endmodule
